// File: rtl/mul_split_seq.sv
// mul_split_seq: sequential A x B multiplier producing the low OUT_WIDTH bits
// of the unsigned product. It uses one A_WIDTH x SLICE multiplier and feeds it
// one slice of b per cycle. Operands arrive and the result leaves over
// valid/ready handshakes, and only one job is in flight at a time.
module mul_split_seq #(
  parameter int A_WIDTH   = 16,
  parameter int B_WIDTH   = 32,
  parameter int SLICE     = 16,
  parameter int OUT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [A_WIDTH-1:0]   a,
  input  logic [B_WIDTH-1:0]   b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out
);

  localparam int N  = B_WIDTH / SLICE;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = A_WIDTH + SLICE;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [A_WIDTH-1:0]   a_q, a_d;
  logic [B_WIDTH-1:0]   b_q, b_d;
  logic [OUT_WIDTH-1:0] acc_q, acc_d;
  logic [KW-1:0]        k_q, k_d;

  logic [SLICE-1:0]     b_slice;
  logic [PW-1:0]        partial;
  logic [OUT_WIDTH-1:0] pp_trunc;
  logic [OUT_WIDTH-1:0] pp_shifted;

  // Select the current b slice and align its partial product. Constant-offset
  // muxes keep the slice and shift logic free of variable part-selects.
  // Truncating to OUT_WIDTH before the left shift is safe because the shift
  // only ever pushes bits further out of the kept range.
  always_comb begin
    b_slice    = '0;
    pp_shifted = '0;
    for (int i = 0; i < N; i++) begin
      if (k_q == KW'(i)) b_slice = b_q[i*SLICE +: SLICE];
    end
    partial  = PW'(a_q) * PW'(b_slice);
    pp_trunc = OUT_WIDTH'(partial);
    for (int i = 0; i < N; i++) begin
      if (k_q == KW'(i)) pp_shifted = pp_trunc << (i*SLICE);
    end
  end

  // Next-state logic: capture on accept, accumulate one slice per cycle,
  // then hold the result until the consumer takes it.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    k_d     = k_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          acc_d   = '0;
          k_d     = '0;
          state_d = MUL;
        end
      end
      MUL: begin
        acc_d = acc_q + pp_shifted;
        if (k_q == KW'(N-1)) begin
          k_d     = '0;
          state_d = DONE;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        k_d     = '0;
        acc_d   = '0;
      end
    endcase
  end

  // State and datapath registers. Reset drops any in-flight job.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      k_q     <= k_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out       = acc_q;

endmodule

// File: tb/tb_mul_split_seq.sv
// Directed and randomized checks for mul_split_seq with default parameters.
module tb_mul_split_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out;

  int pass_count  = 0;
  int check_count = 0;
  int fail_count  = 0;

  mul_split_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One comparison: counts it and reports a failure with observed/expected.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    check_count++;
    assert (observed === expected) pass_count++;
    else begin
      fail_count++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance one clock; inputs and outputs are handled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full job: wait for in_ready, accept, check latency and result, hand off.
  task automatic applyStimulus(input string tag, input logic [15:0] av,
                               input logic [31:0] bv, input logic [31:0] expv);
    int lat;
    int guard;
    guard = 0;
    while (!in_ready && guard < 20) begin
      step();
      guard++;
    end
    checkOutput({tag, "_ready_before"}, 64'(in_ready), 64'd1);
    a        = av;
    b        = bv;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    checkOutput({tag, "_busy"}, 64'(in_ready), 64'd0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    checkOutput({tag, "_latency"}, 64'(lat), 64'd2);
    checkOutput({tag, "_out"}, 64'(out), 64'(expv));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checkOutput({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
    checkOutput({tag, "_ready_back"}, 64'(in_ready), 64'd1);
  endtask

  logic [31:0] exp_q[$];
  int          accept_cycles[$];

  initial begin
    logic [31:0] got_exp;
    logic [47:0] prod;
    logic [31:0] hold_out;
    int          delivered;
    int          issued;
    int          cycles;
    logic        acc_now;
    logic        del_now;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    #12;
    checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_out", 64'(out), 64'd0);
    step();
    rst_n = 1'b1;
    step();

    // Directed arithmetic cases.
    applyStimulus("basic", 16'd3, 32'd5, 32'd15);
    applyStimulus("all_ones", 16'hFFFF, 32'hFFFF_FFFF, 32'hFFFF_0001);
    applyStimulus("upper_slice", 16'h1234, 32'h0001_0000, 32'h1234_0000);
    applyStimulus("carry_drop", 16'h0002, 32'h8000_0000, 32'h0000_0000);
    applyStimulus("mixed", 16'h00AB, 32'h00CD_0001, 32'h88EF_00AB);

    // Backpressure: result held while out_ready is low and inputs churn.
    a        = 16'h00AB;
    b        = 32'h00CD_0001;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    checkOutput("bp_valid", 64'(out_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      in_valid = ~in_valid;
      a        = 16'($urandom);
      b        = $urandom;
      step();
      checkOutput("bp_hold_out", 64'(out), 64'h88EF_00AB);
      checkOutput("bp_hold_valid", 64'(out_valid), 64'd1);
      checkOutput("bp_no_ready", 64'(in_ready), 64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checkOutput("bp_release_ready", 64'(in_ready), 64'd1);
    checkOutput("bp_release_valid", 64'(out_valid), 64'd0);
    step();
    step();
    checkOutput("bp_no_new_job", 64'(out_valid), 64'd0);

    // Reset one cycle after accept: the job is dropped.
    a        = 16'd100;
    b        = 32'd200;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_ready", 64'(in_ready), 64'd1);
    checkOutput("rst_mid_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_mid_out", 64'(out), 64'd0);
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checkOutput("rst_dropped", 64'(out_valid), 64'd0);
    end
    applyStimulus("after_rst", 16'd7, 32'd9, 32'd63);

    // Peak throughput: both handshakes tied high, accepts every 4 cycles.
    in_valid  = 1'b1;
    out_ready = 1'b1;
    a         = 16'd11;
    b         = 32'd13;
    for (int c = 0; c < 18; c++) begin
      if (in_valid && in_ready) accept_cycles.push_back(c);
      step();
    end
    in_valid  = 1'b0;
    step();
    step();
    step();
    checkOutput("tput_accepts", 64'(accept_cycles.size()), 64'd5);
    for (int i = 1; i < accept_cycles.size(); i++) begin
      checkOutput("tput_spacing", 64'(accept_cycles[i] - accept_cycles[i-1]), 64'd4);
    end

    // Randomized traffic checked against an in-order scoreboard.
    out_ready = 1'b0;
    delivered = 0;
    issued    = 0;
    cycles    = 0;
    while (delivered < 1000 && cycles < 40000) begin
      if (!in_valid && issued < 1000 && $urandom_range(0, 1) == 1) begin
        in_valid = 1'b1;
        a        = 16'($urandom);
        b        = $urandom;
      end
      out_ready = 1'($urandom_range(0, 1));
      acc_now   = in_valid && in_ready;
      del_now   = out_valid && out_ready;
      if (del_now) begin
        if (exp_q.size() > 0) got_exp = exp_q.pop_front();
        else got_exp = 32'hDEAD_BEEF;
        checkOutput("rand_out", 64'(out), 64'(got_exp));
        delivered++;
      end
      if (acc_now) begin
        prod = 48'(a) * 48'(b);
        exp_q.push_back(prod[31:0]);
        issued++;
      end
      step();
      if (acc_now) in_valid = 1'b0;
      cycles++;
    end
    checkOutput("rand_delivered", 64'(delivered), 64'd1000);
    checkOutput("rand_leftover", 64'(exp_q.size()), 64'd0);

    hold_out = out;
    $display("[TB] last result %0h", hold_out);
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
